// File: rtl/lr35902_pkg.sv
// Shared LR35902 definitions: OAM DMA state encoding and constants.
// The internal RAM responders implement an edge-strobe contract. A read is captured on the
// first clock edge where read is high after being low. A write commits on the first edge
// where write is low after being high.
package lr35902_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_ISSUE,
        DMA_CAPTURE,
        DMA_WRITE,
        DMA_COMMIT
    } dma_state_t;

    localparam int         OAM_DMA_LEN   = 160;
    localparam logic [7:0] DMA_ECHO_BASE = 8'hE0;
    localparam logic [7:0] DMA_ECHO_OFS  = 8'h20;

    // Echo/IO pages fold back onto work RAM so DMA never reads the IO region.
    function automatic logic [7:0] dma_src_remap(input logic [7:0] hi);
        return (hi >= DMA_ECHO_BASE) ? hi - DMA_ECHO_OFS : hi;
    endfunction

endpackage

// File: rtl/lr35902_oam_dma.sv
// OAM DMA initiator: copies LEN bytes from page {src,00..} into OAM using the
// edge-strobe protocol, one byte per four clocks.
module lr35902_oam_dma
    import lr35902_pkg::*;
#(
    parameter int LEN = OAM_DMA_LEN
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [7:0]  src_hi,
    output logic        busy,
    output logic [15:0] bus_adr,
    output logic        bus_read,
    input  logic [7:0]  bus_din,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_dout,
    output logic        oam_write
);

    localparam logic [7:0] LAST = 8'(LEN - 1);

    dma_state_t state, state_nx;
    logic [7:0] src, src_nx;
    logic [7:0] idx, idx_nx;
    logic [7:0] data, data_nx;
    logic       pend, pend_nx;

    assign bus_adr  = {src, idx};
    assign oam_adr  = idx;
    assign oam_dout = data;

    always_comb begin
        state_nx = state;
        src_nx   = src;
        idx_nx   = idx;
        data_nx  = data;
        pend_nx  = pend;

        // A new source page is latched right away; the running byte still finishes.
        if (start)
            src_nx = dma_src_remap(src_hi);

        case (state)
            DMA_IDLE: begin
                if (start) begin
                    idx_nx   = 8'd0;
                    state_nx = DMA_ISSUE;
                end
            end
            DMA_ISSUE: begin
                if (start) pend_nx = 1'b1;
                state_nx = DMA_CAPTURE;
            end
            DMA_CAPTURE: begin
                if (start) pend_nx = 1'b1;
                data_nx  = bus_din;
                state_nx = DMA_WRITE;
            end
            DMA_WRITE: begin
                if (start) pend_nx = 1'b1;
                state_nx = DMA_COMMIT;
            end
            DMA_COMMIT: begin
                // A start arriving in COMMIT itself restarts too, even on the last byte.
                if (pend || start) begin
                    pend_nx  = 1'b0;
                    idx_nx   = 8'd0;
                    state_nx = DMA_ISSUE;
                end else if (idx == LAST) begin
                    state_nx = DMA_IDLE;
                end else begin
                    idx_nx   = idx + 8'd1;
                    state_nx = DMA_ISSUE;
                end
            end
            default: state_nx = DMA_IDLE;
        endcase
    end

    // Strobes and busy are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= DMA_IDLE;
            src       <= 8'd0;
            idx       <= 8'd0;
            data      <= 8'd0;
            pend      <= 1'b0;
            busy      <= 1'b0;
            bus_read  <= 1'b0;
            oam_write <= 1'b0;
        end else begin
            state     <= state_nx;
            src       <= src_nx;
            idx       <= idx_nx;
            data      <= data_nx;
            pend      <= pend_nx;
            busy      <= (state_nx != DMA_IDLE);
            bus_read  <= (state_nx == DMA_ISSUE);
            oam_write <= (state_nx == DMA_WRITE);
        end
    end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Bench for lr35902_oam_dma: source RAM model, scoreboard of expected OAM commits
// (address, data, commit edge) and strobe protocol checks.
module tb_lr35902_oam_dma;
    import lr35902_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_hi = 8'h00;
    logic [7:0]  bus_din = 8'h00;
    logic        busy, bus_read, oam_write;
    logic [15:0] bus_adr;
    logic [7:0]  oam_adr, oam_dout;

    always #5 clk = ~clk;

    lr35902_oam_dma #(.LEN(160)) dut (
        .clk(clk), .nreset(nreset), .start(start), .src_hi(src_hi),
        .busy(busy), .bus_adr(bus_adr), .bus_read(bus_read), .bus_din(bus_din),
        .oam_adr(oam_adr), .oam_dout(oam_dout), .oam_write(oam_write)
    );

    typedef struct {
        logic [7:0] adr;
        logic [7:0] dat;
        int         ed;
    } exp_t;

    exp_t       sbq[$];
    int         ecount = 0;
    int         total = 0, bad = 0;
    int         n_rd = 0, n_wr = 0, n_busy = 0;
    logic [7:0] exp_page = 8'h00;
    logic       rd_last = 1'b0, w_last = 1'b0, rd_q = 1'b0;

    function automatic logic [7:0] srcf(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) ecount <= ecount + 1;

    // Source RAM responder: loads its output on the rising edge of read.
    always @(posedge clk) begin
        rd_q <= bus_read;
        if (bus_read && !rd_q) bus_din <= srcf(bus_adr);
    end

    task automatic chk(input logic [63:0] got, input logic [63:0] exp, input string tag);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) n_busy++;
            if (bus_read) begin
                n_rd++;
                chk(64'(rd_last), 64'd0, "read_back_to_back");
                chk(64'(bus_adr[15:8]), 64'(exp_page), "read_page");
            end
            if (oam_write) begin
                n_wr++;
                chk(64'(w_last), 64'd0, "write_back_to_back");
                chk(64'(sbq.size() > 0), 64'd1, "write_expected");
                if (sbq.size() > 0)
                    chk(64'({oam_adr, oam_dout}), 64'({sbq[0].adr, sbq[0].dat}), "write_data");
            end
            // COMMIT cycle: OAM takes adr/dout on the next edge.
            if (w_last && !oam_write) begin
                chk(64'(oam_adr < 8'd160), 64'd1, "oam_adr_range");
                chk(64'(sbq.size() > 0), 64'd1, "commit_expected");
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk(64'({oam_adr, oam_dout, 32'(ecount + 1)}),
                        64'({e.adr, e.dat, 32'(e.ed)}), "commit_adr_dat_edge");
                end
            end
            rd_last = bus_read;
            w_last  = oam_write;
        end
    endtask

    task automatic push_copy(input logic [7:0] pg, input int n, input int base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.adr = 8'(i);
            e.dat = srcf({pg, 8'(i)});
            e.ed  = base + 4 * (i + 1);
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(64'(busy), 64'd0, tag);
    endtask

    task automatic wait_edge(input int target, input string tag);
        int k = 0;
        while (ecount != target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(64'(ecount), 64'(target), tag);
    endtask

    task automatic run_full(input logic [7:0] s, input logic [7:0] pg, input string tag);
        int t0, r0, w0, b0;
        exp_page = pg;
        r0 = n_rd; w0 = n_wr; b0 = n_busy;
        @(negedge clk);
        start = 1'b1; src_hi = s; t0 = ecount + 1;
        push_copy(pg, 160, t0);
        @(negedge clk);
        start = 1'b0;
        wait_idle(1000, {tag, "_idle"});
        chk(64'(n_rd - r0), 64'd160, {tag, "_reads"});
        chk(64'(n_wr - w0), 64'd160, {tag, "_writes"});
        chk(64'(n_busy - b0), 64'd640, {tag, "_busy_cycles"});
        chk(64'(sbq.size()), 64'd0, {tag, "_all_committed"});
    endtask

    initial begin
        int t0, r0, w0, b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk(64'({busy, bus_read, oam_write, bus_adr, oam_adr, oam_dout}), 64'd0, "reset_outputs");
        @(negedge clk);
        #2 nreset = 1'b1;
        repeat (2) @(negedge clk);
        chk(64'(busy), 64'd0, "idle_after_reset");

        run_full(8'hC1, 8'hC1, "copy_c1");
        run_full(8'hFE, 8'hDE, "copy_fe_remap");
        run_full(8'hDF, 8'hDF, "copy_df");

        // Restart during WRITE of byte 37.
        exp_page = 8'hC1;
        r0 = n_rd; w0 = n_wr; b0 = n_busy;
        @(negedge clk);
        start = 1'b1; src_hi = 8'hC1; t0 = ecount + 1;
        push_copy(8'hC1, 38, t0);
        @(negedge clk);
        start = 1'b0;
        wait_edge(t0 + 150, "reach_write37");
        chk(64'({oam_write, oam_adr}), 64'({1'b1, 8'd37}), "in_write37");
        start = 1'b1; src_hi = 8'hC2; exp_page = 8'hC2;
        push_copy(8'hC2, 160, t0 + 152);
        @(negedge clk);
        start = 1'b0;
        wait_idle(1200, "restart_idle");
        chk(64'(n_busy - b0), 64'(38 * 4 + 640), "restart_busy_cycles");
        chk(64'(n_rd - r0), 64'd198, "restart_reads");
        chk(64'(n_wr - w0), 64'd198, "restart_writes");
        chk(64'(sbq.size()), 64'd0, "restart_all_committed");

        // Reset asserted in ISSUE of byte 10.
        exp_page = 8'hC1;
        r0 = n_rd; w0 = n_wr;
        @(negedge clk);
        start = 1'b1; src_hi = 8'hC1; t0 = ecount + 1;
        push_copy(8'hC1, 10, t0);
        @(negedge clk);
        start = 1'b0;
        wait_edge(t0 + 40, "reach_issue10");
        chk(64'({bus_read, bus_adr}), 64'({1'b1, 16'hC10A}), "in_issue10");
        #2 nreset = 1'b0;
        #1 chk(64'({busy, bus_read, oam_write, bus_adr, oam_adr, oam_dout}), 64'd0, "async_reset_outputs");
        repeat (2) @(negedge clk);
        #2 nreset = 1'b1;
        repeat (20) @(negedge clk);
        chk(64'(busy), 64'd0, "idle_after_release");
        chk(64'(sbq.size()), 64'd0, "reset_bytes0_9_committed");
        chk(64'(n_rd - r0), 64'd11, "reset_reads");
        chk(64'(n_wr - w0), 64'd10, "reset_writes");

        // Start held for three cycles: one queued restart after byte 0.
        exp_page = 8'hC3;
        r0 = n_rd; w0 = n_wr; b0 = n_busy;
        @(negedge clk);
        start = 1'b1; src_hi = 8'hC3; t0 = ecount + 1;
        push_copy(8'hC3, 1, t0);
        push_copy(8'hC3, 160, t0 + 4);
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle(1200, "held_idle");
        chk(64'(n_busy - b0), 64'd644, "held_busy_cycles");
        chk(64'(n_rd - r0), 64'd161, "held_reads");
        chk(64'(n_wr - w0), 64'd161, "held_writes");
        chk(64'(sbq.size()), 64'd0, "held_all_committed");

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
